// File: rtl/alu_muldiv.sv
// Iterative 32-bit multiply/divide unit, one result bit per clock.
// Shift-add MUL/MULH and restoring DIVU/REMU with NZCV flag output.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       inflags,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       outflags
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             v_q, v_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flg_q, flg_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;
  logic [WIDTH-1:0] fin;
  logic             fin_c;
  logic [WIDTH-1:0] dz_res;

  // Only the V bit of the incoming flags is carried through.
  logic unused_flags;
  assign unused_flags = ^inflags[3:1];

  // One iteration of the shared datapath.
  always_comb begin
    addend  = lo_q[0] ? a_q : '0;
    mul_sum = {1'b0, hi_q} + {1'b0, addend};
    trial   = {hi_q, lo_q[WIDTH-1]};
    ge      = (trial >= {1'b0, b_q});
    diff    = trial[WIDTH-1:0] - b_q;
    if (!op_q[1]) begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_step = ge ? diff : trial[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], ge};
    end
    fin    = op_q[0] ? hi_step : lo_step;
    fin_c  = (op_q == 2'b00) && (|hi_step);
    dz_res = op[0] ? a : '1;
  end

  // Next-state and register-next logic for the control FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    v_d     = v_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    flg_d   = flg_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          op_d  = op;
          v_d   = inflags[0];
          cnt_d = '0;
          if (op[1] && (b == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            res_d   = dz_res;
            flg_d   = {dz_res[WIDTH-1], dz_res == '0,
                       1'b0, 1'b1};
          end else begin
            state_d = S_RUN;
            hi_d    = '0;
            lo_d    = op[1] ? a : b;
          end
        end
      end
      S_RUN: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          res_d   = fin;
          flg_d   = {fin[WIDTH-1], fin == '0, fin_c, v_q};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset discards any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      v_q     <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      v_q     <= v_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = res_q;
  assign outflags = flg_q;

endmodule
